// File: rtl/npn_lut_stream.sv
// npn_lut_stream: two-stage valid/ready evaluator of an NIN-input function
// stored as truth table + NPN transform (input perm, input neg, output neg).
// Ports:
//   clk, rst             clock, async active-high reset
//   cfg_valid/cfg_ready  config request / LOAD-cycle acknowledge
//   cfg_tt               truth table, bit k = output for transformed value k
//   cfg_perm             NIN fields of PW bits, source input per z bit
//   cfg_neg_in           per-transformed-bit input negation
//   cfg_neg_out          output negation
//   in_valid/in_ready    input vector handshake, in_x = vector
//   out_valid/out_ready  result handshake, out_y = result
//   cfg_err              sticky bad-permutation flag
// Optional macro NPN_PERM_CHECK_EN: reject non-bijective permutations in
// LOAD and set cfg_err; otherwise perm is written unchecked, cfg_err = 0.

module npn_lut_stream #(
    parameter int NIN  = 4,
    parameter int TT_W = 2**NIN,
    parameter int PW   = $clog2(NIN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [TT_W-1:0]   cfg_tt,
    input  logic [NIN*PW-1:0] cfg_perm,
    input  logic [NIN-1:0]    cfg_neg_in,
    input  logic              cfg_neg_out,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [NIN-1:0]    in_x,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_y,
    output logic              cfg_err
);

    typedef enum logic [1:0] {RUN, DRAIN, LOAD} state_t;

    state_t state_q, state_d;

    logic [TT_W-1:0]   tt_q;
    logic [NIN*PW-1:0] perm_q;
    logic [NIN-1:0]    neg_in_q;
    logic              neg_out_q;

    logic              s1_v_q;
    logic [NIN-1:0]    z_q, z_d;
    logic              s2_v_q;
    logic              y_q, y_d;

    logic              s1_load, s2_load, in_acc;
    logic              run_st, load_st;
    logic              perm_ok;

    function automatic logic [NIN*PW-1:0] ident_perm();
        logic [NIN*PW-1:0] r;
        r = '0;
        for (int i = 0; i < NIN; i++) begin
            r[i*PW +: PW] = PW'(i);
        end
        return r;
    endfunction

    // Field values >= NIN wrap so the select can never leave in_x.
    function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] f);
        int unsigned v;
        v = int'(f) % NIN;
        return PW'(v);
    endfunction

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN: begin
                if (cfg_valid) state_d = DRAIN;
            end
            DRAIN: begin
                if (!cfg_valid) begin
                    state_d = RUN;
                end else if (!s1_v_q && !s2_v_q) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                state_d = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        run_st  = 1'b0;
        load_st = 1'b0;
        unique case (state_q)
            RUN:     run_st  = 1'b1;
            LOAD:    load_st = 1'b1;
            default: ;
        endcase
    end

    assign cfg_ready = load_st;

    // ---------------- Permutation check ----------------
`ifdef NPN_PERM_CHECK_EN
    logic [NIN-1:0] seen;
    logic           err_q;

    always_comb begin
        seen = '0;
        for (int i = 0; i < NIN; i++) begin
            for (int j = 0; j < NIN; j++) begin
                if (cfg_perm[i*PW +: PW] == PW'(j)) seen[j] = 1'b1;
            end
        end
        perm_ok = &seen;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (load_st && !perm_ok) begin
            err_q <= 1'b1;
        end
    end

    assign cfg_err = err_q;
`else
    assign perm_ok = 1'b1;
    assign cfg_err = 1'b0;
`endif

    // ---------------- Config registers ----------------
    // Written only in LOAD, which is reached with both stages empty, so
    // in-flight items always see the old configuration.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tt_q      <= '0;
            perm_q    <= ident_perm();
            neg_in_q  <= '0;
            neg_out_q <= 1'b0;
        end else if (load_st && perm_ok) begin
            tt_q      <= cfg_tt;
            perm_q    <= cfg_perm;
            neg_in_q  <= cfg_neg_in;
            neg_out_q <= cfg_neg_out;
        end
    end

    // ---------------- Datapath ----------------
    assign s2_load  = !s2_v_q || out_ready;
    assign s1_load  = !s1_v_q || s2_load;
    assign in_ready = !rst && run_st && s1_load;
    assign in_acc   = in_valid && in_ready;

    always_comb begin
        z_d = '0;
        for (int i = 0; i < NIN; i++) begin
            z_d[i] = in_x[wrap_idx(perm_q[i*PW +: PW])] ^ neg_in_q[i];
        end
    end

    assign y_d = tt_q[z_q] ^ neg_out_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v_q <= 1'b0;
            z_q    <= '0;
            s2_v_q <= 1'b0;
            y_q    <= 1'b0;
        end else begin
            if (s1_load) begin
                s1_v_q <= in_acc;
                if (in_acc) z_q <= z_d;
            end
            if (s2_load) begin
                s2_v_q <= s1_v_q;
                if (s1_v_q) y_q <= y_d;
            end
        end
    end

    assign out_valid = s2_v_q;
    assign out_y     = y_q;

endmodule

// File: tb/tb_npn_lut_stream.sv
// tb_npn_lut_stream: directed vectors with hand-computed expectations for
// npn_lut_stream (NIN = 4).

module tb_npn_lut_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [15:0] cfg_tt;
    logic [7:0]  cfg_perm;
    logic [3:0]  cfg_neg_in;
    logic        cfg_neg_out;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_x;
    logic        out_valid;
    logic        out_ready;
    logic        out_y;
    logic        cfg_err;

    int n_cmp = 0;
    int n_bad = 0;

    npn_lut_stream #(.NIN(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_tt      (cfg_tt),
        .cfg_perm    (cfg_perm),
        .cfg_neg_in  (cfg_neg_in),
        .cfg_neg_out (cfg_neg_out),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_x        (in_x),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_y       (out_y),
        .cfg_err     (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_cfg(input logic [15:0] tt, input logic [7:0] perm,
                            input logic [3:0] ni, input logic no);
        bit done;
        done        = 1'b0;
        cfg_valid   = 1'b1;
        cfg_tt      = tt;
        cfg_perm    = perm;
        cfg_neg_in  = ni;
        cfg_neg_out = no;
        for (int k = 0; k < 20 && !done; k++) begin
            tick();
            if (cfg_ready) done = 1'b1;
        end
        check("cfg_ready_seen", 32'(done), 1);
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic push1(input string tag, input logic [3:0] x,
                         input logic e);
        in_valid = 1'b1;
        in_x     = x;
        check({tag, "_rdy"}, 32'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        tick();
        check({tag, "_ov"}, 32'(out_valid), 1);
        check({tag, "_y"}, 32'(out_y), 32'(e));
        tick();
    endtask

    task automatic run2(input string tag, input logic [3:0] x0,
                        input logic [3:0] x1, input logic e0,
                        input logic e1);
        in_valid = 1'b1;
        in_x     = x0;
        check({tag, "_rdy"}, 32'(in_ready), 1);
        tick();
        in_x = x1;
        tick();
        in_valid = 1'b0;
        check({tag, "_ov0"}, 32'(out_valid), 1);
        check({tag, "_y0"}, 32'(out_y), 32'(e0));
        tick();
        check({tag, "_ov1"}, 32'(out_valid), 1);
        check({tag, "_y1"}, 32'(out_y), 32'(e1));
        tick();
        check({tag, "_idle"}, 32'(out_valid), 0);
    endtask

    logic [3:0] bp [3];
    logic       bp_e [3];
    logic       got [$];
    int         acc;
    int         at;
    int         nout;

    initial begin
        rst         = 1'b1;
        cfg_valid   = 1'b0;
        cfg_tt      = '0;
        cfg_perm    = '0;
        cfg_neg_in  = '0;
        cfg_neg_out = 1'b0;
        in_valid    = 1'b0;
        in_x        = '0;
        out_ready   = 1'b1;
        bp   = '{4'h4, 4'h0, 4'h4};
        bp_e = '{1'b1, 1'b0, 1'b1};

        // Reset state
        tick();
        in_valid = 1'b1;
        in_x     = 4'hF;
        #1;
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_y", 32'(out_y), 0);
        check("rst_cfg_ready", 32'(cfg_ready), 0);
        check("rst_cfg_err", 32'(cfg_err), 0);
        tick();
        rst = 1'b0;
        #1;

        // Default tt = 0, latency 2
        check("def_rdy", 32'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        check("def_lat1", 32'(out_valid), 0);
        tick();
        check("def_lat2", 32'(out_valid), 1);
        check("def_y", 32'(out_y), 0);
        tick();
        check("def_done", 32'(out_valid), 0);

        // AND4
        load_cfg(16'h8000, 8'hE4, 4'h0, 1'b0);
        run2("and4", 4'hF, 4'h7, 1'b1, 1'b0);

        // Permutation: z0 = x2
        load_cfg(16'hAAAA, 8'hE6, 4'h0, 1'b0);
        run2("perm", 4'b0100, 4'b0001, 1'b1, 1'b0);
        load_cfg(16'hAAAA, 8'hE6, 4'h0, 1'b1);
        run2("perm_no", 4'b0100, 4'b0001, 1'b0, 1'b1);

        // Input negation on z0: y = !x2
        load_cfg(16'hAAAA, 8'hE6, 4'h1, 1'b0);
        push1("negin", 4'b0100, 1'b0);

        // Backpressure, y = x2
        load_cfg(16'hAAAA, 8'hE6, 4'h0, 1'b0);
        out_ready = 1'b0;
        acc       = 0;
        in_valid  = 1'b1;
        in_x      = bp[0];
        for (int c = 0; c < 4; c++) begin
            if (in_ready) acc++;
            tick();
            if (acc < 3) in_x = bp[acc];
        end
        check("bp_accepted", 32'(acc), 2);
        check("bp_in_ready", 32'(in_ready), 0);
        check("bp_ov", 32'(out_valid), 1);
        check("bp_hold_y", 32'(out_y), 1);
        tick();
        check("bp_hold_y2", 32'(out_y), 1);
        out_ready = 1'b1;
        got.delete();
        for (int c = 0; c < 12 && got.size() < 3; c++) begin
            if (out_valid) got.push_back(out_y);
            if (in_valid && in_ready) acc++;
            tick();
            if (acc < 3) in_x = bp[acc];
            else in_valid = 1'b0;
        end
        in_valid = 1'b0;
        check("bp_count", 32'(got.size()), 3);
        for (int i = 0; i < 3; i++) begin
            if (i < got.size()) check("bp_order", 32'(got[i]), 32'(bp_e[i]));
        end
        tick();
        check("bp_empty", 32'(out_valid), 0);

        // Reconfigure with two items in flight
        load_cfg(16'h8000, 8'hE4, 4'h0, 1'b0);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_x      = 4'hF;
        tick();
        in_x = 4'h0;
        tick();
        in_valid    = 1'b0;
        cfg_valid   = 1'b1;
        cfg_tt      = 16'hFFFF;
        cfg_perm    = 8'hE4;
        cfg_neg_in  = 4'h0;
        cfg_neg_out = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("rc_wait", 32'(cfg_ready), 0);
        end
        out_ready = 1'b1;
        got.delete();
        at   = -1;
        nout = 0;
        for (int c = 0; c < 20 && at < 0; c++) begin
            if (cfg_ready) begin
                at = nout;
            end else begin
                if (out_valid) begin
                    got.push_back(out_y);
                    nout++;
                end
                tick();
            end
        end
        check("rc_ready_after", 32'(at), 2);
        check("rc_nout", 32'(got.size()), 2);
        if (got.size() == 2) begin
            check("rc_old0", 32'(got[0]), 1);
            check("rc_old1", 32'(got[1]), 0);
        end
        tick();
        cfg_valid = 1'b0;
        check("rc_ready_pulse", 32'(cfg_ready), 0);
        push1("rc_new", 4'h0, 1'b1);

        // Non-bijective permutation {0,0,1,2}, new tt = 0
        load_cfg(16'h0000, 8'h90, 4'h0, 1'b0);
`ifdef NPN_PERM_CHECK_EN
        check("pc_err", 32'(cfg_err), 1);
        push1("pc_keep", 4'hF, 1'b1);
`else
        check("pc_err", 32'(cfg_err), 0);
        push1("pc_keep", 4'hF, 1'b0);
`endif

        // Reset mid-stream
        load_cfg(16'hFFFF, 8'hE4, 4'h0, 1'b0);
        in_valid = 1'b1;
        in_x     = 4'hF;
        tick();
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        check("mr_ov", 32'(out_valid), 0);
        check("mr_rdy", 32'(in_ready), 0);
        check("mr_err", 32'(cfg_err), 0);
        tick();
        rst = 1'b0;
        #1;
        tick();
        check("mr_flushed", 32'(out_valid), 0);
        push1("mr_tt0", 4'hF, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

endmodule
